crop_stream_sequencer: RTL and testbench

// - Sequences one inference of the CNN core (myproject): pulses its ap_start and crops an OUT_ROWSxOUT_COLS

---
 rtl/crop_stream_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_crop_stream_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/crop_stream_sequencer.sv
// Crops a window from a frame buffer, streams it into the CNN core and collects one beat per output stream.
// Optional watchdog in the stream/collect phase: define CROP_TIMEOUT_EN.
module crop_stream_sequencer #(
  parameter int DATA_W      = 16,
  parameter int IN_ROWS     = 100,
  parameter int IN_COLS     = 160,
  parameter int OUT_ROWS    = 48,
  parameter int OUT_COLS    = 48,
  parameter int N_OUT       = 5,
  parameter int ADDR_W      = 15,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    start,
  input  logic [6:0]              crop_y1,
  input  logic [7:0]              crop_x1,
  output logic                    busy,
  output logic                    done,
  output logic                    err_bounds,
  output logic                    err_timeout,
  output logic                    mem_ren,
  output logic [ADDR_W-1:0]       mem_raddr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    dut_ap_start,
  input  logic                    dut_ap_done,
  output logic [DATA_W-1:0]       pix_TDATA,
  output logic                    pix_TVALID,
  input  logic                    pix_TREADY,
  input  logic [N_OUT*DATA_W-1:0] res_TDATA,
  input  logic [N_OUT-1:0]        res_TVALID,
  output logic [N_OUT-1:0]        res_TREADY,
  output logic [N_OUT*DATA_W-1:0] result,
  output logic                    result_valid
);

  localparam int NPIX = OUT_ROWS * OUT_COLS;
  localparam int CW   = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW   = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  // Jump from the last column of one crop row to the first column of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_COLS - OUT_COLS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_KICK, S_STREAM, S_WAIT_OUT, S_DONE} state_t;

  state_t                  r_state;
  logic [6:0]              r_y1;
  logic [7:0]              r_x1;
  logic [ADDR_W-1:0]       r_raddr;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic                    r_rd_done;
  logic                    r_inflight;
  logic [DATA_W-1:0]       r_fifo [2];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_occ;
  logic [PW-1:0]           r_pix_cnt;
  logic [N_OUT-1:0]        r_cap;
  logic [N_OUT*DATA_W-1:0] r_result;
  logic                    r_done_seen;
  logic                    r_done;
  logic                    r_err_bounds;
  logic                    r_res_vld;

  logic                    w_streaming;
  logic                    w_collect;
  logic                    w_pop;
  logic [2:0]              w_credit;
  logic                    w_ren;
  logic [N_OUT-1:0]        w_res_hs;
  logic                    w_last_pix;
  logic                    w_oob;
  logic                    w_to_expire;

  assign w_streaming = (r_state == S_STREAM);
  assign w_collect   = w_streaming || (r_state == S_WAIT_OUT);
  assign pix_TVALID  = w_streaming && (r_occ != 2'd0);
  assign pix_TDATA   = r_fifo[r_rptr];
  assign w_pop       = pix_TVALID && pix_TREADY;
  // A read may be issued when the FIFO can absorb it, counting the entry freed by this cycle's pop.
  assign w_credit    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_ren       = ((r_state == S_KICK) || w_streaming) && !r_rd_done &&
                       ((w_credit < 3'd2) || ((w_credit == 3'd2) && w_pop));
  assign res_TREADY  = {N_OUT{w_collect}} & ~r_cap;
  assign w_res_hs    = res_TVALID & res_TREADY;
  assign w_last_pix  = w_pop && (r_pix_cnt == PW'(NPIX - 1));
  assign w_oob       = ((32'(r_y1) + 32'(OUT_ROWS)) > 32'(IN_ROWS)) ||
                       ((32'(r_x1) + 32'(OUT_COLS)) > 32'(IN_COLS));

  assign busy         = (r_state != S_IDLE);
  assign dut_ap_start = (r_state == S_KICK);
  assign mem_ren      = w_ren;
  assign mem_raddr    = r_raddr;
  assign done         = r_done;
  assign err_bounds   = r_err_bounds;
  assign result       = r_result;
  assign result_valid = r_res_vld;

`ifdef CROP_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err_timeout;
  logic        w_any_hs;

  assign w_any_hs    = w_pop || (|w_res_hs);
  assign w_to_expire = w_collect && !w_any_hs && (r_to_cnt == 16'(TIMEOUT_CYC - 1));
  assign err_timeout = r_err_timeout;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_to_cnt      <= 16'd0;
      r_err_timeout <= 1'b0;
    end else begin
      if (!w_collect || w_any_hs) r_to_cnt <= 16'd0;
      else                        r_to_cnt <= r_to_cnt + 16'd1;
      r_err_timeout <= w_to_expire;
    end
  end
`else
  assign w_to_expire = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_y1         <= '0;
      r_x1         <= '0;
      r_raddr      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_rd_done    <= 1'b0;
      r_inflight   <= 1'b0;
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_occ        <= 2'd0;
      r_pix_cnt    <= '0;
      r_cap        <= '0;
      r_result     <= '0;
      r_done_seen  <= 1'b0;
      r_done       <= 1'b0;
      r_err_bounds <= 1'b0;
      r_res_vld    <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_err_bounds <= 1'b0;
      r_res_vld    <= 1'b0;

      if (w_ren) begin
        if (r_col == CW'(OUT_COLS - 1)) begin
          r_col   <= '0;
          r_row   <= r_row + RW'(1);
          r_raddr <= r_raddr + ROW_STEP;
          if (r_row == RW'(OUT_ROWS - 1)) r_rd_done <= 1'b1;
        end else begin
          r_col   <= r_col + CW'(1);
          r_raddr <= r_raddr + ADDR_W'(1);
        end
      end
      r_inflight <= w_ren;

      // Read data lands one cycle after mem_ren and goes straight into the FIFO.
      if (r_inflight) begin
        r_fifo[r_wptr] <= mem_rdata;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr    <= ~r_rptr;
        r_pix_cnt <= r_pix_cnt + PW'(1);
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

      for (int k = 0; k < N_OUT; k++) begin
        if (w_res_hs[k]) begin
          r_cap[k]                          <= 1'b1;
          r_result[k*DATA_W +: DATA_W]      <= res_TDATA[k*DATA_W +: DATA_W];
        end
      end

      if (dut_ap_done && (r_state == S_KICK || w_collect)) r_done_seen <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_y1    <= crop_y1;
            r_x1    <= crop_x1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_oob) begin
            r_done       <= 1'b1;
            r_err_bounds <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_raddr     <= ADDR_W'(32'(r_y1) * 32'(IN_COLS) + 32'(r_x1));
            r_col       <= '0;
            r_row       <= '0;
            r_rd_done   <= 1'b0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= 2'd0;
            r_pix_cnt   <= '0;
            r_cap       <= '0;
            r_done_seen <= 1'b0;
            r_state     <= S_KICK;
          end
        end
        S_KICK: r_state <= S_STREAM;
        S_STREAM: begin
          if (w_to_expire) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_last_pix) begin
            r_state <= S_WAIT_OUT;
          end
        end
        S_WAIT_OUT: begin
          if (w_to_expire) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if ((&r_cap) && r_done_seen) begin
            r_done    <= 1'b1;
            r_res_vld <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_stream_sequencer.sv
// Bench for crop_stream_sequencer: frame-buffer model, randomized core handshakes, window reference model.
module tb_crop_stream_sequencer;
  localparam int DATA_W = 16;
  localparam int N_OUT  = 5;
  localparam int ADDR_W = 15;
  localparam int IN_COLS = 160;
  localparam int OUT_COLS = 48;
  localparam int NPIX   = 48 * 48;
  localparam int FRAME  = 100 * 160;

  logic                    ap_clk, ap_rst_n, start;
  logic [6:0]              crop_y1;
  logic [7:0]              crop_x1;
  logic                    busy, done, err_bounds, err_timeout, mem_ren;
  logic [ADDR_W-1:0]       mem_raddr;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    dut_ap_start, dut_ap_done;
  logic [DATA_W-1:0]       pix_TDATA;
  logic                    pix_TVALID, pix_TREADY;
  logic [N_OUT*DATA_W-1:0] res_TDATA;
  logic [N_OUT-1:0]        res_TVALID, res_TREADY;
  logic [N_OUT*DATA_W-1:0] result;
  logic                    result_valid;

  logic [DATA_W-1:0] frame [0:FRAME-1];
  int n_cmp, n_err;

  crop_stream_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .crop_y1(crop_y1), .crop_x1(crop_x1),
    .busy(busy), .done(done), .err_bounds(err_bounds), .err_timeout(err_timeout),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dut_ap_start(dut_ap_start), .dut_ap_done(dut_ap_done),
    .pix_TDATA(pix_TDATA), .pix_TVALID(pix_TVALID), .pix_TREADY(pix_TREADY),
    .res_TDATA(res_TDATA), .res_TVALID(res_TVALID), .res_TREADY(res_TREADY),
    .result(result), .result_valid(result_valid)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk)
    if (mem_ren) mem_rdata <= (int'(mem_raddr) < FRAME) ? frame[mem_raddr] : 16'hDEAD;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, done, err_bounds, err_timeout, mem_ren, mem_raddr, dut_ap_start,
              pix_TDATA, pix_TVALID, res_TREADY, result, result_valid}, 128'd0);
  endtask

  task automatic run_crop(input int y1, input int x1, input bit rnd_rdy, input int done_at,
                          input int abort_at, input bit bad, input bit fixed_vals);
    int cyc, beats, pix_err, stab_err, reads, starts, dones, rvs, bnds, tos;
    int cyc_start, cyc_first, hs_first, hs_last, multi;
    bit fin, aborted, done_given, prev_stall;
    logic [DATA_W-1:0] prev_data, exp_pix;
    logic [DATA_W-1:0] val [N_OUT];
    bit got [N_OUT];
    bit vhold [N_OUT];
    int acc [N_OUT];
    logic [N_OUT*DATA_W-1:0] exp_res;
    beats = 0; pix_err = 0; stab_err = 0; reads = 0; starts = 0; dones = 0; rvs = 0;
    bnds = 0; tos = 0; cyc_start = -1; cyc_first = -1; hs_first = 0; hs_last = 0;
    fin = 0; aborted = 0; done_given = 0; prev_stall = 0; prev_data = '0;
    for (int k = 0; k < N_OUT; k++) begin
      val[k] = fixed_vals ? DATA_W'(17 * (k + 1)) : DATA_W'($urandom);
      exp_res[k*DATA_W +: DATA_W] = val[k];
      got[k] = 0; vhold[k] = 0; acc[k] = 0;
    end
    res_TVALID = '0; res_TDATA = '0; dut_ap_done = 0;
    for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge ap_clk);
      start   = (cyc == 0) || (beats == 100);
      crop_y1 = (cyc == 0) ? 7'(y1) : 7'd0;
      crop_x1 = (cyc == 0) ? 8'(x1) : 8'd0;
      pix_TREADY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      dut_ap_done = (starts > 0) && (beats == done_at) && !done_given;
      if (dut_ap_done) done_given = 1;
      for (int k = 0; k < N_OUT; k++) begin
        if (starts > 0 && !got[k]) begin
          if (!vhold[k]) vhold[k] = ($urandom_range(0, 3) == 0);
          res_TVALID[k] = vhold[k];
          res_TDATA[k*DATA_W +: DATA_W] = val[k];
        end else if (got[k] && k == 2) begin
          res_TVALID[k] = 1'b1;
          res_TDATA[k*DATA_W +: DATA_W] = ~val[k];
        end else begin
          res_TVALID[k] = 1'b0;
        end
      end
      #1;
      if (dut_ap_start) begin starts++; cyc_start = cyc; end
      if (mem_ren) reads++;
      if (pix_TVALID && cyc_first < 0) cyc_first = cyc;
      if (prev_stall && (!pix_TVALID || pix_TDATA !== prev_data)) stab_err++;
      if (pix_TVALID && pix_TREADY) begin
        exp_pix = frame[(y1 + beats / OUT_COLS) * IN_COLS + x1 + beats % OUT_COLS];
        if (pix_TDATA !== exp_pix) pix_err++;
        if (beats == 0) hs_first = cyc;
        hs_last = cyc;
        beats++;
      end
      prev_stall = pix_TVALID && !pix_TREADY;
      prev_data  = pix_TDATA;
      for (int k = 0; k < N_OUT; k++)
        if (res_TVALID[k] && res_TREADY[k]) begin acc[k]++; got[k] = 1; vhold[k] = 0; end
      if (result_valid) rvs++;
      if (err_bounds) bnds++;
      if (err_timeout) tos++;
      if (done) begin
        dones++;
        chk("done_result_valid", result_valid, !bad);
        chk("done_err_bounds", err_bounds, bad);
        chk("done_busy", busy, !bad);
        fin = 1;
      end
      if (abort_at >= 0 && beats == abort_at && !fin) begin
        ap_rst_n = 1'b0;
        #1;
        chk_all_zero("abort_outputs_zero");
        aborted = 1;
        fin = 1;
      end
    end
    start = 0; dut_ap_done = 0;
    if (!fin) chk("run_cycle_budget", 1'b0, 1'b1);
    if (aborted) begin
      repeat (3) @(negedge ap_clk);
      #1 chk_all_zero("abort_held_zero");
      chk("abort_no_done", dones, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
    end else if (bad) begin
      chk("bounds_err_count", bnds, 1);
      chk("bounds_no_ap_start", starts, 0);
      chk("bounds_no_mem_ren", reads, 0);
      chk("bounds_no_result_valid", rvs, 0);
    end else begin
      multi = 0;
      for (int k = 0; k < N_OUT; k++) if (acc[k] != 1) multi++;
      chk("beat_count", beats, NPIX);
      chk("pixel_errors", pix_err, 0);
      chk("stall_stability_errors", stab_err, 0);
      chk("mem_read_count", reads, NPIX);
      chk("ap_start_count", starts, 1);
      chk("first_valid_latency", cyc_first - cyc_start, 2);
      chk("result_valid_count", rvs, 1);
      chk("err_pulses", bnds + tos, 0);
      chk("streams_not_once", multi, 0);
      chk("result_vector", result, exp_res);
      if (!rnd_rdy) chk("full_rate_span", hs_last - hs_first, NPIX - 1);
      res_TVALID = '0;
      repeat (4) @(negedge ap_clk);
      #1;
      chk("result_held", result, exp_res);
      chk("idle_after_done", {busy, done, result_valid}, 3'b000);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    ap_rst_n = 1'b0; start = 0; crop_y1 = '0; crop_x1 = '0; mem_rdata = '0;
    dut_ap_done = 0; pix_TREADY = 0; res_TDATA = '0; res_TVALID = '0;
    for (int a = 0; a < FRAME; a++) frame[a] = DATA_W'(a);
    repeat (3) @(negedge ap_clk);
    #1 chk_all_zero("reset_outputs_zero");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_crop(10, 10, 1'b0, 500, -1, 1'b0, 1'b1);
    run_crop(10, 10, 1'b1, NPIX, -1, 1'b0, 1'b1);
    run_crop(53, 0, 1'b0, 0, -1, 1'b1, 1'b1);
    run_crop(0, 113, 1'b0, 0, -1, 1'b1, 1'b1);

    for (int a = 0; a < FRAME; a++) frame[a] = DATA_W'($urandom);
    run_crop(52, 112, 1'b1, 0, -1, 1'b0, 1'b0);
    run_crop(0, 0, 1'b0, 1200, -1, 1'b0, 1'b0);
    run_crop(int'($urandom_range(0, 52)), int'($urandom_range(0, 112)), 1'b1,
             int'($urandom_range(0, NPIX)), -1, 1'b0, 1'b0);

    run_crop(10, 10, 1'b0, 500, 1000, 1'b0, 1'b1);
    run_crop(10, 10, 1'b0, 500, -1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
